// File: rtl/sync_filter.sv
// Multi-channel level synchronizer with an optional per-channel stability
// filter and one-cycle rise/fall edge pulses on the synchronized level.
module sync_filter #(
  parameter int              WIDTH       = 8,
  parameter int              NSYNC       = 2,
  parameter int              FILT_CYCLES = 0,
  parameter logic [WIDTH-1:0] RST_VAL    = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_async,
  output logic [WIDTH-1:0] o_sync,
  output logic [WIDTH-1:0] o_rise,
  output logic [WIDTH-1:0] o_fall
);

  // Illegal parameter sets stop elaboration rather than building a broken chain.
  if (NSYNC < 2 || NSYNC > 8 || FILT_CYCLES < 0 || FILT_CYCLES > 255 || WIDTH < 1) begin : g_bad_params
    $fatal(1, "sync_filter: illegal parameters NSYNC=%0d FILT_CYCLES=%0d WIDTH=%0d",
           NSYNC, FILT_CYCLES, WIDTH);
  end

  logic [WIDTH-1:0] r_chain [NSYNC];
  logic [WIDTH-1:0] w_last;
  logic [WIDTH-1:0] w_sync;
  logic [WIDTH-1:0] r_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NSYNC; k++) begin
        r_chain[k] <= RST_VAL;
      end
    end else begin
      r_chain[0] <= i_async;
      for (int k = 1; k < NSYNC; k++) begin
        r_chain[k] <= r_chain[k-1];
      end
    end
  end

  assign w_last = r_chain[NSYNC-1];

  if (FILT_CYCLES == 0) begin : g_nofilt
    assign w_sync = w_last;
  end else begin : g_filt
    localparam int CW = $clog2(FILT_CYCLES + 1);

    for (genvar c = 0; c < WIDTH; c++) begin : g_chan
      logic [CW-1:0] r_cnt;
      logic          r_out;

      // Output only follows the chain after FILT_CYCLES consecutive disagreeing
      // cycles; any agreement in between restarts the count.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_cnt <= '0;
          r_out <= RST_VAL[c];
        end else if (w_last[c] == r_out) begin
          r_cnt <= '0;
        end else if (r_cnt == CW'(FILT_CYCLES - 1)) begin
          r_out <= w_last[c];
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end

      assign w_sync[c] = r_out;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev <= RST_VAL;
    end else begin
      r_prev <= w_sync;
    end
  end

  assign o_sync = w_sync;
  assign o_rise = w_sync & ~r_prev;
  assign o_fall = ~w_sync & r_prev;

endmodule

// File: tb/tb_sync_filter.sv
// Directed and model-checked random bench for sync_filter across several
// parameter sets sharing one clock, reset and input bus.
module tb_sync_filter;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] stim = 4'h0;

   int checks = 0;
   int failures = 0;

   logic [3:0] s0, r0, f0;
   logic [3:0] s1, r1, f1;
   logic [3:0] s2, r2, f2;
   logic [3:0] s3, r3, f3;
   logic [3:0] s4, r4, f4;
   logic [3:0] s5, r5, f5;
   logic [3:0] s6, r6, f6;

   // Directed instances
   sync_filter #(.WIDTH(4), .NSYNC(2), .FILT_CYCLES(0), .RST_VAL(4'b0000)) u0 (
      .clk(clk), .rst(rst), .i_async(stim), .o_sync(s0), .o_rise(r0), .o_fall(f0));
   sync_filter #(.WIDTH(4), .NSYNC(3), .FILT_CYCLES(3), .RST_VAL(4'b0000)) u1 (
      .clk(clk), .rst(rst), .i_async(stim), .o_sync(s1), .o_rise(r1), .o_fall(f1));
   sync_filter #(.WIDTH(4), .NSYNC(2), .FILT_CYCLES(0), .RST_VAL(4'b0101)) u2 (
      .clk(clk), .rst(rst), .i_async(stim), .o_sync(s2), .o_rise(r2), .o_fall(f2));
   sync_filter #(.WIDTH(4), .NSYNC(2), .FILT_CYCLES(4), .RST_VAL(4'b0010)) u3 (
      .clk(clk), .rst(rst), .i_async(stim), .o_sync(s3), .o_rise(r3), .o_fall(f3));

   // Random-run instances, checked against the reference model
   sync_filter #(.WIDTH(4), .NSYNC(2), .FILT_CYCLES(0), .RST_VAL(4'b0000)) u4 (
      .clk(clk), .rst(rst), .i_async(stim), .o_sync(s4), .o_rise(r4), .o_fall(f4));
   sync_filter #(.WIDTH(4), .NSYNC(3), .FILT_CYCLES(1), .RST_VAL(4'b0000)) u5 (
      .clk(clk), .rst(rst), .i_async(stim), .o_sync(s5), .o_rise(r5), .o_fall(f5));
   sync_filter #(.WIDTH(4), .NSYNC(2), .FILT_CYCLES(5), .RST_VAL(4'b0000)) u6 (
      .clk(clk), .rst(rst), .i_async(stim), .o_sync(s6), .o_rise(r6), .o_fall(f6));

   always #5 clk = ~clk;

   // Reference model state for the three random-run instances
   int         nsArr [3] = '{2, 3, 2};
   int         fArr  [3] = '{0, 1, 5};
   logic [3:0] mChain [3][8];
   logic [3:0] mOut  [3];
   logic [3:0] mPrev [3];
   int         mCnt  [3][4];

   task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic [3:0] value, input logic rstValue);
      @(negedge clk);
      stim = value;
      rst  = rstValue;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic modelReset();
      for (int k = 0; k < 3; k++) begin
         for (int s = 0; s < 8; s++) mChain[k][s] = 4'h0;
         for (int c = 0; c < 4; c++) mCnt[k][c] = 0;
         mOut[k]  = 4'h0;
         mPrev[k] = 4'h0;
      end
   endtask

   // One rising edge of the reference model, evaluated from pre-edge state
   task automatic modelStep(input int k);
      logic [3:0] lastStage;
      logic [3:0] nextOut;
      lastStage = mChain[k][nsArr[k]-1];
      nextOut   = mOut[k];
      mPrev[k]  = mOut[k];
      if (fArr[k] > 0) begin
         for (int c = 0; c < 4; c++) begin
            if (lastStage[c] != mOut[k][c]) begin
               mCnt[k][c] = mCnt[k][c] + 1;
               if (mCnt[k][c] == fArr[k]) begin
                  nextOut[c] = lastStage[c];
                  mCnt[k][c] = 0;
               end
            end else begin
               mCnt[k][c] = 0;
            end
         end
      end
      for (int s = nsArr[k] - 1; s > 0; s--) mChain[k][s] = mChain[k][s-1];
      mChain[k][0] = stim;
      if (fArr[k] == 0) nextOut = mChain[k][nsArr[k]-1];
      mOut[k] = nextOut;
   endtask

   task automatic checkRandom(input int k, input logic [3:0] sy, input logic [3:0] ri, input logic [3:0] fa);
      logic [3:0] expRise;
      logic [3:0] expFall;
      expRise = mOut[k] & ~mPrev[k];
      expFall = ~mOut[k] & mPrev[k];
      checkOutput($sformatf("rand%0d_sync", k), {4'h0, sy}, {4'h0, mOut[k]});
      checkOutput($sformatf("rand%0d_rise", k), {4'h0, ri}, {4'h0, expRise});
      checkOutput($sformatf("rand%0d_fall", k), {4'h0, fa}, {4'h0, expFall});
   endtask

   initial begin
      // Reset state
      #1 rst = 1'b1;
      #1;
      checkOutput("rst_u0_sync", {4'h0, s0}, 8'h00);
      checkOutput("rst_u0_rise", {4'h0, r0}, 8'h00);
      checkOutput("rst_u0_fall", {4'h0, f0}, 8'h00);
      checkOutput("rst_u2_sync", {4'h0, s2}, 8'h05);
      checkOutput("rst_u3_sync", {4'h0, s3}, 8'h02);
      tick();

      // Plain synchronizer latency and rise pulse
      applyStimulus(4'hA, 1'b0);
      tick();
      checkOutput("A_e1_sync", {4'h0, s0}, 8'h00);
      checkOutput("A_e1_rise", {4'h0, r0}, 8'h00);
      tick();
      checkOutput("A_e2_sync", {4'h0, s0}, 8'h0A);
      checkOutput("A_e2_rise", {4'h0, r0}, 8'h0A);
      checkOutput("A_e2_fall", {4'h0, f0}, 8'h00);
      tick();
      checkOutput("A_e3_rise", {4'h0, r0}, 8'h00);
      checkOutput("A_e3_sync", {4'h0, s0}, 8'h0A);

      // Simultaneous rise and fall on different channels
      applyStimulus(4'h3, 1'b0);
      tick();
      tick();
      checkOutput("B_3_sync", {4'h0, s0}, 8'h03);
      checkOutput("B_3_rise", {4'h0, r0}, 8'h01);
      checkOutput("B_3_fall", {4'h0, f0}, 8'h08);
      tick();
      checkOutput("B_3_rise_idle", {4'h0, r0}, 8'h00);
      checkOutput("B_3_fall_idle", {4'h0, f0}, 8'h00);
      applyStimulus(4'hC, 1'b0);
      tick();
      checkOutput("B_C_e1_sync", {4'h0, s0}, 8'h03);
      tick();
      checkOutput("B_C_sync", {4'h0, s0}, 8'h0C);
      checkOutput("B_C_rise", {4'h0, r0}, 8'h0C);
      checkOutput("B_C_fall", {4'h0, f0}, 8'h03);
      checkOutput("B_C_overlap", {4'h0, r0 & f0}, 8'h00);

      // Filter rejects a two-cycle glitch, then accepts a held level
      applyStimulus(4'h0, 1'b1);
      tick();
      applyStimulus(4'h1, 1'b0);
      for (int i = 0; i < 8; i++) begin
         tick();
         checkOutput($sformatf("C_glitch%0d_sync", i), {7'h0, s1[0]}, 8'h00);
         checkOutput($sformatf("C_glitch%0d_rise", i), {7'h0, r1[0]}, 8'h00);
         if (i == 1) applyStimulus(4'h0, 1'b0);
      end
      applyStimulus(4'h1, 1'b0);
      for (int i = 1; i <= 7; i++) begin
         tick();
         checkOutput($sformatf("C_hold%0d_sync", i), {7'h0, s1[0]}, (i >= 6) ? 8'h01 : 8'h00);
         checkOutput($sformatf("C_hold%0d_rise", i), {7'h0, r1[0]}, (i == 6) ? 8'h01 : 8'h00);
      end

      // Non-zero reset value with matching input through release
      checkOutput("D_pre_u2_sync", {4'h0, s2}, 8'h01);
      applyStimulus(4'h5, 1'b1);
      #1;
      checkOutput("D_async_u2_sync", {4'h0, s2}, 8'h05);
      tick();
      checkOutput("D_rst_u2_sync", {4'h0, s2}, 8'h05);
      applyStimulus(4'h5, 1'b0);
      for (int i = 1; i <= 4; i++) begin
         tick();
         checkOutput($sformatf("D_rel%0d_sync", i), {4'h0, s2}, 8'h05);
         checkOutput($sformatf("D_rel%0d_rise", i), {4'h0, r2}, 8'h00);
         checkOutput($sformatf("D_rel%0d_fall", i), {4'h0, f2}, 8'h00);
      end

      // Reset in the middle of a filter count restarts the full latency
      applyStimulus(4'h2, 1'b1);
      tick();
      applyStimulus(4'h2, 1'b0);
      for (int i = 0; i < 4; i++) tick();
      checkOutput("E_stable_u3_sync", {4'h0, s3}, 8'h02);
      applyStimulus(4'h0, 1'b0);
      for (int i = 1; i <= 5; i++) begin
         tick();
         checkOutput($sformatf("E_count%0d_sync", i), {4'h0, s3}, 8'h02);
      end
      checkOutput("E_pre_u2_sync", {4'h0, s2}, 8'h00);
      #2 rst = 1'b1;
      #1;
      checkOutput("E_async_u3_sync", {4'h0, s3}, 8'h02);
      checkOutput("E_async_u2_sync", {4'h0, s2}, 8'h05);
      applyStimulus(4'h0, 1'b0);
      for (int i = 1; i <= 6; i++) begin
         tick();
         checkOutput($sformatf("E_rel%0d_sync", i), {4'h0, s3}, (i >= 6) ? 8'h00 : 8'h02);
         checkOutput($sformatf("E_rel%0d_fall", i), {4'h0, f3}, (i == 6) ? 8'h02 : 8'h00);
      end

      // Random inputs against the reference model for F = 0, 1 and 5
      applyStimulus(4'h0, 1'b1);
      tick();
      modelReset();
      applyStimulus(4'h0, 1'b0);
      for (int n = 0; n < 3000; n++) begin
         @(posedge clk);
         for (int k = 0; k < 3; k++) modelStep(k);
         #1;
         checkRandom(0, s4, r4, f4);
         checkRandom(1, s5, r5, f5);
         checkRandom(2, s6, r6, f6);
         if ($urandom_range(0, 5) == 0) stim = 4'($urandom_range(0, 15));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
